lsu_byte_lane: RTL and testbench
================================

Name: lsu_byte_lane

Overview:
- Load/store unit between the MEM pipeline stage and the word-addressed 32-bit data memory (2048 words, 1-cycle registered read, no byte enables).
- Converts RV32I byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
- Loads: extracts and sign- or zero-extends the addressed lane.
- Sub-word stores: performed as read-modify-write; detects misaligned or illegal accesses.

Parameters:
- DEPTH_WORDS, 2048, number of data memory words; power of 2.
- AW, 11, word-address width = log2(DEPTH_WORDS).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; handshake = req_valid & req_ready
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, lane in bits [7:0]/[15:0]/[31:0]
- resp_valid  out  1  one-cycle completion pulse for every accepted request
- resp_err  out  1  valid with resp_valid; misaligned/illegal access
- resp_rdata  out  32  extended load data; 0 for stores and errors
- mem_addr  out  32  word address = {zeros, byte_addr[AW+1:2]}
- mem_write_data  out  32  word written
- mem_memwrite  out  1  write strobe
- mem_memread  out  1  read strobe
- mem_read_data  in  32  memory output, valid the cycle after mem_memread

Behaviour:
- Reset (sync, active-high): state = IDLE; resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - mem_memread and mem_memwrite forced to 0 in any cycle where rst = 1.
- FSM states: IDLE, LOAD_WAIT, STORE_MERGE.
- Request fields are captured on accept: addr, funct3, wdata.
- Memory outputs are combinational: from the live request in IDLE, from the captured registers otherwise.
- Error check on accept; an error causes no memory strobe, state stays IDLE, and resp_valid = 1, resp_err = 1 at T+1.
  - Misaligned: H/HU with addr[0] = 1; W with addr[1:0] != 0.
  - Illegal funct3: 011, 110, 111 for loads; anything other than 000/001/010 for stores.
- Load (accept at T):
  - T: mem_memread = 1; go to LOAD_WAIT.
  - T+1: select lane by addr[1:0] (byte) or addr[1] (halfword); extend (B/H sign, BU/HU zero); register result; go to IDLE.
  - T+2: resp_valid = 1 with resp_rdata.
- SW (accept at T): mem_memwrite = 1 at T with req_wdata; stays IDLE; resp_valid at T+1.
- SB/SH (accept at T):
  - T: mem_memread = 1; go to STORE_MERGE.
  - T+1: mem_write_data = mem_read_data with the addressed lane replaced by wdata[7:0] or wdata[15:0]; mem_memwrite = 1; go to IDLE.
  - T+2: resp_valid = 1.
- mem_memread and mem_memwrite are never high in the same cycle.
- Address bits above AW+1 are ignored; accesses wrap modulo DEPTH_WORDS.
- resp_valid may coincide with acceptance of the next request; back-to-back requests are legal.
- Reset mid-operation: the pending op is abandoned and no response is issued.
  - Reset in STORE_MERGE suppresses the write; memory is unchanged.
- No outstanding-request queue; at most one request in flight.

Optional Feature:
- Macro LSU_RANGE_CHECK_EN.
- Defined: req_addr[31:AW+2] != 0 is treated as an error (no access; resp_err = 1 at T+1).
- Undefined: the upper address bits are ignored and accesses wrap as described above.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state encoding (2 bits);
  - lane-select helper constants.
- One sub-module, lsu_lane_align: purely combinational.
  - Load path: extract + extend.
  - Store path: merge.
  - Shared by the load and store paths.

Test Plan:
- Memory word 5 = 0x8081_82F3; LB at byte addr 0x16 -> resp_rdata 0xFFFF_FF81 at T+2, resp_err 0.
  - LBU at 0x16 -> 0x0000_0081.
  - LHU at 0x16 -> 0x0000_8081.
- SW 0xDEAD_BEEF at 0x20; then SB 0x55 at 0x21 -> word 8 = 0xDEAD_55EF.
  - Then LW at 0x20 returns 0xDEAD_55EF.
  - Check: no memread/memwrite overlap in any cycle.
- LH at 0x13, SW at 0x22, funct3 = 011 load -> each gives resp_valid with resp_err = 1 at T+1; no memory strobes; memory unchanged.
- Back-to-back LW, SH, LW with req_valid held high:
  - req_ready drops for exactly one cycle after each LW/SH;
  - responses arrive in order with the correct data.
- rst asserted during the STORE_MERGE cycle of SH 0xAAAA at 0x40:
  - mem_memwrite stays 0; word 16 unchanged; no resp_valid; req_ready = 1 the cycle after rst deasserts.
- Out-of-range address:
  - With LSU_RANGE_CHECK_EN: LW at 0x0000_2000 -> resp_err = 1.
  - Without it: the same LW reads word 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store byte-lane unit: funct3 codes,
// FSM state encoding, lane-select constants and access legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_LOAD_WAIT   = 2'd1,
        ST_STORE_MERGE = 2'd2
    } state_t;

    // Byte lane by addr[1:0], halfword lane by addr[1]
    localparam logic [1:0] LANE_B0  = 2'd0;
    localparam logic [1:0] LANE_B1  = 2'd1;
    localparam logic [1:0] LANE_B2  = 2'd2;
    localparam logic [1:0] LANE_B3  = 2'd3;
    localparam logic       LANE_HLO = 1'b0;
    localparam logic       LANE_HHI = 1'b1;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3 == F3_H || f3 == F3_HU) && off[0]) || (f3 == F3_W && off != 2'd0);
    endfunction

    function automatic logic is_illegal(input logic wr, input logic [2:0] f3);
        if (wr)
            return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends a load lane from a memory
// word, and merges store data into the addressed lane of a memory word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            LANE_B0: byte_sel = rd_word[7:0];
            LANE_B1: byte_sel = rd_word[15:8];
            LANE_B2: byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = (offset[1] == LANE_HHI) ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_data = rd_word;
            F3_BU:   load_data = {24'b0, byte_sel};
            F3_HU:   load_data = {16'b0, half_sel};
            default: load_data = 32'b0;
        endcase
    end

    always_comb begin
        merge_data = rd_word;
        case (funct3)
            F3_B: begin
                case (offset)
                    LANE_B0: merge_data[7:0]   = wdata[7:0];
                    LANE_B1: merge_data[15:8]  = wdata[7:0];
                    LANE_B2: merge_data[23:16] = wdata[7:0];
                    default: merge_data[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (offset[1] == LANE_HLO)
                    merge_data[15:0] = wdata[15:0];
                else
                    merge_data[31:16] = wdata[15:0];
            end
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_byte_lane.sv
// Load/store unit mapping RV32I byte-addressed accesses onto a word memory.
// Build option LSU_RANGE_CHECK_EN: addresses beyond the memory become errors.
//
// state          | meaning
// ST_IDLE        | ready; errors and SW complete from here directly
// ST_LOAD_WAIT   | memory word arriving; extract lane and register result
// ST_STORE_MERGE | memory word arriving; merge lane and write back
module lsu_byte_lane
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 2048,
    parameter int AW          = $clog2(DEPTH_WORDS)
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_read_data
);

    state_t      state, state_nxt;
    logic [AW+1:0] addr_q, cur_addr;
    logic [2:0]  f3_q;
    logic [31:0] wdata_q;
    logic        accept, req_err, range_err, is_sw;
    logic [31:0] load_data, merge_data;
    logic        resp_valid_nxt, resp_err_nxt;
    logic [31:0] resp_rdata_nxt;

`ifdef LSU_RANGE_CHECK_EN
    assign range_err = |req_addr[31:AW+2];
`else
    // Upper address bits are ignored so accesses wrap around the memory
    assign range_err = 1'b0 & (|req_addr[31:AW+2]);
`endif

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid & req_ready;
    assign is_sw     = req_write && (req_funct3 == F3_W);
    assign req_err   = is_misaligned(req_funct3, req_addr[1:0])
                     | is_illegal(req_write, req_funct3) | range_err;

    assign cur_addr  = (state == ST_IDLE) ? req_addr[AW+1:0] : addr_q;
    assign mem_addr  = {{(32-AW){1'b0}}, cur_addr[AW+1:2]};

    lsu_lane_align u_align (
        .funct3     (f3_q),
        .offset     (addr_q[1:0]),
        .rd_word    (mem_read_data),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr[AW+1:0];
            f3_q    <= req_funct3;
            wdata_q <= req_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && !req_err) begin
                    if (!req_write)
                        state_nxt = ST_LOAD_WAIT;
                    else if (!is_sw)
                        state_nxt = ST_STORE_MERGE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_memread    = 1'b0;
        mem_memwrite   = 1'b0;
        mem_write_data = merge_data;
        resp_valid_nxt = 1'b0;
        resp_err_nxt   = 1'b0;
        resp_rdata_nxt = 32'b0;
        case (state)
            ST_IDLE: begin
                mem_write_data = req_wdata;
                if (accept) begin
                    if (req_err) begin
                        resp_valid_nxt = 1'b1;
                        resp_err_nxt   = 1'b1;
                    end else if (is_sw) begin
                        mem_memwrite   = 1'b1;
                        resp_valid_nxt = 1'b1;
                    end else begin
                        mem_memread    = 1'b1;
                    end
                end
            end
            ST_LOAD_WAIT: begin
                resp_valid_nxt = 1'b1;
                resp_rdata_nxt = load_data;
            end
            ST_STORE_MERGE: begin
                mem_memwrite   = 1'b1;
                resp_valid_nxt = 1'b1;
            end
            default: ;
        endcase
        // A reset cycle abandons the pending op, including a merge write-back
        if (rst) begin
            mem_memread  = 1'b0;
            mem_memwrite = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'b0;
        end else begin
            resp_valid <= resp_valid_nxt;
            resp_err   <= resp_err_nxt;
            resp_rdata <= resp_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_lsu_byte_lane.sv
// Scoreboard bench for lsu_byte_lane: byte-level reference model plus a
// behavioural word memory; a monitor checks every response against the queue.
module tb_lsu_byte_lane;
    import lsu_pkg::*;

    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_addr, mem_write_data;
    logic        mem_memwrite, mem_memread;
    logic [31:0] mem_read_data = 32'b0;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_byte_lane #(.DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
        .mem_read_data(mem_read_data)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'h8081_82F3;
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Word memory with a one-cycle registered read
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_memwrite) mem[mem_addr[10:0]] <= mem_write_data;
            if (mem_memread)  mem_read_data <= mem[mem_addr[10:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic bit model_err(input bit wr, input logic [2:0] f3, input logic [31:0] a);
        bit ill, mis;
        if (wr) ill = (f3 > 3'd2);
        else    ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
`ifdef LSU_RANGE_CHECK_EN
        if ((a >> 13) != 0) ill = 1'b1;
`endif
        return ill || mis;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'h80)   ? b - 32'h100   : b;
            3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] w, input logic [31:0] wd);
        int sh;
        logic [31:0] m;
        if (f3 == 3'd0) begin
            sh = 8 * off;  m = 32'hFF << sh;
        end else if (f3 == 3'd1) begin
            sh = 16 * off[1];  m = 32'hFFFF << sh;
        end else begin
            return wd;
        end
        return (w & ~m) | ((wd << sh) & m);
    endfunction

    task automatic issue(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit hold, input bit abandon,
                         output int stalls);
        exp_t e;
        bit   err;
        int   w, acc, lat;
        err = model_err(wr, f3, a);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            stalls++;
            if (stalls > 8) begin
                chk("req_ready_timeout", 32'(stalls), 32'd0);
                req_valid = 1'b0;
                return;
            end
        end
        chk("accept_memread",  mem_memread,  !err && !(wr && f3 == F3_W));
        chk("accept_memwrite", mem_memwrite, !err && wr && f3 == F3_W);
        @(posedge clk); #1;
        acc = cyc;
        if (!hold) req_valid = 1'b0;
        if (abandon) return;
        w = widx(a);
        e.err = err;
        e.rdata = 32'h0;
        if (err) begin
            lat = 1;
        end else if (!wr) begin
            lat = 2;
            e.rdata = model_load(f3, a[1:0], ref_mem[w]);
        end else begin
            lat = (f3 == F3_W) ? 1 : 2;
            ref_mem[w] = model_store(f3, a[1:0], ref_mem[w], wd);
        end
        e.cyc = acc + lat - 1;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        chk("drain_pending", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        chk("strobe_overlap", {31'b0, mem_memread & mem_memwrite}, 32'd0);
        if (rst) chk("rst_strobes", {30'b0, mem_memread, mem_memwrite}, 32'd0);
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("resp_err",   resp_err,   mon_e.err);
                chk("resp_rdata", resp_rdata, mon_e.rdata);
                chk("resp_cycle", 32'(cyc),   32'(mon_e.cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st, diffs;
        bit wr, hold;
        logic [2:0] f3;
        logic [31:0] a;
        logic [2:0] legal [5];
        legal = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_err",   resp_err,   1'b0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        @(posedge clk); #1;

        issue(0, F3_B,  32'h16, 32'h0, 0, 0, st);
        issue(0, F3_BU, 32'h16, 32'h0, 0, 0, st);
        issue(0, F3_HU, 32'h16, 32'h0, 0, 0, st);
        issue(1, F3_W,  32'h20, 32'hDEAD_BEEF, 0, 0, st);
        issue(1, F3_B,  32'h21, 32'h0000_0055, 0, 0, st);
        issue(0, F3_W,  32'h20, 32'h0, 0, 0, st);
        issue(0, F3_H,  32'h13, 32'h0, 0, 0, st);
        issue(1, F3_W,  32'h22, 32'h1234_5678, 0, 0, st);
        issue(0, 3'b011, 32'h0, 32'h0, 0, 0, st);
        drain();

        issue(0, F3_W, 32'h20, 32'h0, 1, 0, st);
        issue(1, F3_H, 32'h26, 32'h0000_1234, 1, 0, st);
        chk("b2b_stall_after_lw", 32'(st), 32'd1);
        issue(0, F3_W, 32'h24, 32'h0, 1, 0, st);
        chk("b2b_stall_after_sh", 32'(st), 32'd1);
        issue(1, F3_W, 32'h30, 32'hCAFE_F00D, 0, 0, st);
        chk("b2b_stall_after_lw2", 32'(st), 32'd1);
        drain();

        issue(1, F3_H, 32'h40, 32'h0000_AAAA, 0, 1, st);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_merge_memwrite", mem_memwrite, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1'b1);
        chk("no_resp_after_rst", resp_valid, 1'b0);
        @(posedge clk); #1;
        issue(0, F3_W, 32'h40, 32'h0, 0, 0, st);
        issue(0, F3_W, 32'h0000_2000, 32'h0, 0, 0, st);
        drain();

        for (int i = 0; i < 300; i++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1)
                a = a & ~((f3 == 3'd2) ? 32'd3 : ((f3 == 3'd1 || f3 == 3'd5) ? 32'd1 : 32'd0));
            if ($urandom_range(0, 7) == 0) a = a | ($urandom() << 13);
            hold = (i != 299) && ($urandom_range(0, 1) == 1);
            issue(wr, f3, a, $urandom(), hold, 0, st);
            if (!hold) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        drain();

        diffs = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk("mem_image_diffs", 32'(diffs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
